// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX write-port arbiter.
// Contents: FSM state encoding, counter widths and a helper that sizes the
// source index from the requester count.
package uart_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int BEAT_CNT_W = 8;
  localparam int IDLE_CNT_W = 16;

  // Width of a source index; never below one bit.
  function automatic int src_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between the requesters, the arbiter and the TX FIFO write
// port.
// Signals:
//   src_valid/src_data/src_last : per-source byte offer (source i at [8i+7:8i])
//   src_ready                   : per-source accept
//   uart_tx_fifo_req/data       : FIFO write strobe and byte
//   uart_tx_fifo_full           : FIFO full
// Modports: master = arbiter, slave = requesters plus FIFO side.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 uart_tx_fifo_req;
  logic [7:0]           uart_tx_fifo_data;
  logic                 uart_tx_fifo_full;

  modport master (
    input  src_valid, src_data, src_last, uart_tx_fifo_full,
    output src_ready, uart_tx_fifo_req, uart_tx_fifo_data
  );

  modport slave (
    output src_valid, src_data, src_last, uart_tx_fifo_full,
    input  src_ready, uart_tx_fifo_req, uart_tx_fifo_data
  );
endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin pick.
// Ports:
//   valid      in  per-source request vector
//   last_grant in  index of the previous owner
//   pick       out first valid index scanning upward from last_grant+1 with wrap
//   any_valid  out at least one request present
module rr_priority_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = src_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   pick,
  output logic               any_valid
);

  logic [SRC_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid source
  // (lowest offset after last_grant) is the one left standing.
  always_comb begin
    pick      = last_grant;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (valid[idx]) begin
        pick      = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX FIFO write port.
// A grant is held from the first byte through the byte flagged last; a
// length limit and an idle timeout release runaway or stalled owners.
// Ports:
//   uart_tx_fifo_clk  in  sole clock, rising edge
//   reset             in  synchronous, active high
//   bus               --  uart_tx_arbiter_if.master (sources + FIFO write)
//   grant_id          out current / most recent owner
//   busy              out a grant is active
//   err_timeout       out one-cycle pulse after an idle-timeout release
//   err_len           out one-cycle pulse after a length-limit release
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int TIMEOUT     = 1024,
  localparam int SRC_W      = src_width(NUM_SRC)
) (
  input  logic               uart_tx_fifo_clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus,
  output logic [SRC_W-1:0]   grant_id,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_len
);

  localparam logic [BEAT_CNT_W-1:0] BEAT_LIMIT = BEAT_CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic [IDLE_CNT_W-1:0]  idle_cnt;

  logic [7:0]             src_bytes [NUM_SRC];
  logic [SRC_W-1:0]       pick;
  logic                   any_valid;
  logic                   in_xfer;
  logic                   sel_valid;
  logic                   beat;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_bytes[i] = bus.src_data[8*i +: 8];
    end
  end

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_picker (
    .valid      (bus.src_valid),
    .last_grant (grant_id),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  assign in_xfer   = (state == ST_XFER);
  assign sel_valid = bus.src_valid[grant_id];
  assign beat      = in_xfer & sel_valid & ~bus.uart_tx_fifo_full;

  // Straight pass-through from the owner to the FIFO; the source holds its
  // byte while the FIFO is full.
  always_comb begin
    bus.src_ready = '0;
    if (in_xfer) begin
      bus.src_ready[grant_id] = ~bus.uart_tx_fifo_full;
    end
  end

  assign bus.uart_tx_fifo_req  = beat;
  assign bus.uart_tx_fifo_data = src_bytes[grant_id];

  always_ff @(posedge uart_tx_fifo_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_id    <= SRC_W'(NUM_SRC - 1);
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            idle_cnt <= '0;
            state    <= ST_XFER;
            busy     <= 1'b1;
          end
        end
        ST_XFER: begin
          if (beat) begin
            idle_cnt <= '0;
            if (bus.src_last[grant_id]) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (beat_cnt == BEAT_LIMIT) begin
              // Rest of this source's stream re-arbitrates as a new packet.
              state   <= ST_IDLE;
              busy    <= 1'b0;
              err_len <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
          end else if (!sel_valid) begin
            // Stalls caused by a full FIFO are not the owner's fault and
            // do not advance the idle counter.
            if (idle_cnt == IDLE_LIMIT) begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              err_timeout <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_SRC=4, MAX_PKT_LEN=4,
// TIMEOUT=8). Sources are byte queues that advance on valid & ready; a
// packet-level model predicts every output each cycle, and directed
// scenarios pin write cycles, data and error pulses with literal values.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;
  localparam int TMO  = 8;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic full = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_SRC(N)) bus ();

  logic [SW-1:0] grant_id;
  logic          busy;
  logic          err_timeout;
  logic          err_len;

  uart_tx_arbiter #(
    .NUM_SRC     (N),
    .MAX_PKT_LEN (MAXL),
    .TIMEOUT     (TMO)
  ) dut (
    .uart_tx_fifo_clk (clk),
    .reset            (rst),
    .bus              (bus),
    .grant_id         (grant_id),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .err_len          (err_len)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // source byte stores: {last, data}
  logic [8:0] srcbuf [N][32];
  int head [N];
  int tail [N];

  // observed activity
  int         wr_cyc [$];
  logic [7:0] wr_dat [$];
  int         el_cyc [$];
  int         et_cyc [$];

  int e_off [8];
  int e_dat [8];

  // packet-level model
  bit m_known = 0;
  int m_owner = -1;
  int m_last  = N - 1;
  int m_sent  = 0;
  int m_quiet = 0;
  bit m_plen  = 0;
  bit m_pto   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic last);
    srcbuf[s][tail[s]] = {last, d};
    tail[s]++;
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_dat.delete();
    el_cyc.delete();
    et_cyc.delete();
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] l, input logic fl, input logic r);
    m_plen = 0;
    m_pto  = 0;
    if (r) begin
      m_known = 1;
      m_owner = -1;
      m_last  = N - 1;
      m_sent  = 0;
      m_quiet = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && v[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_sent  = 0;
        m_quiet = 0;
      end
    end else if (v[m_owner] && !fl) begin
      m_sent++;
      m_quiet = 0;
      if (l[m_owner]) begin
        m_owner = -1;
      end else if (m_sent == MAXL) begin
        m_owner = -1;
        m_plen  = 1;
      end
    end else if (!v[m_owner]) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_owner = -1;
        m_pto   = 1;
      end
    end
  endtask

  // One clock: drive sources, compare at the falling edge, step the model,
  // then advance source queues on the accepted bytes.
  task automatic cycle();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [N-1:0]   acc;
    logic [N-1:0]   exp_ready;
    logic [8*N-1:0] dflat;
    logic           exp_req;
    v     = '0;
    l     = '0;
    dflat = '0;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        v[i]             = 1'b1;
        l[i]             = srcbuf[i][head[i]][8];
        dflat[8*i +: 8]  = srcbuf[i][head[i]][7:0];
      end
    end
    bus.src_valid         = v;
    bus.src_last          = l;
    bus.src_data          = dflat;
    bus.uart_tx_fifo_full = full;

    @(negedge clk);
    cyc++;
    if (m_known) begin
      exp_ready = '0;
      if (m_owner >= 0 && !full) exp_ready[m_owner] = 1'b1;
      exp_req = (m_owner >= 0) && v[m_owner] && !full;
      check("busy", busy, m_owner >= 0);
      check("grant_id", grant_id, m_last);
      check("src_ready", bus.src_ready, exp_ready);
      check("fifo_req", bus.uart_tx_fifo_req, exp_req);
      if (exp_req) check("fifo_data", bus.uart_tx_fifo_data, dflat[8*m_owner +: 8]);
      check("err_len", err_len, m_plen);
      check("err_timeout", err_timeout, m_pto);
    end
    if (bus.uart_tx_fifo_req === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(bus.uart_tx_fifo_data);
    end
    if (err_len === 1'b1) el_cyc.push_back(cyc);
    if (err_timeout === 1'b1) et_cyc.push_back(cyc);
    acc = bus.src_ready & v;
    model_step(v, l, full, rst);

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] === 1'b1) head[i]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic expect_writes(input string tag, input int base, input int n);
    check({tag, "_wr_count"}, wr_cyc.size(), n);
    for (int k = 0; k < n && k < wr_cyc.size(); k++) begin
      check({tag, "_wr_cycle"}, wr_cyc[k], base + e_off[k]);
      check({tag, "_wr_data"}, {24'h0, wr_dat[k]}, e_dat[k]);
    end
  endtask

  int c0;
  int c1;

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst  = 1'b1;
    full = 1'b0;
    run(2);
    rst = 1'b0;
    check("rst_grant_id", grant_id, 3);
    check("rst_busy", busy, 0);
    check("rst_fifo_req", bus.uart_tx_fifo_req, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_err", {err_len, err_timeout}, 0);

    // src0 three-byte packet after reset
    clear_logs();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    c0 = cyc + 1;
    run(8);
    e_off = '{1, 2, 3, 0, 0, 0, 0, 0};
    e_dat = '{'h41, 'h42, 'h43, 0, 0, 0, 0, 0};
    expect_writes("t1", c0, 3);
    check("t1_grant_id", grant_id, 0);
    check("t1_busy", busy, 0);

    // make src1 the last owner, then src1 and src2 request together
    push(1, 8'h10, 1'b1);
    run(4);
    clear_logs();
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    c0 = cyc + 1;
    run(10);
    e_off = '{1, 2, 4, 5, 0, 0, 0, 0};
    e_dat = '{'h21, 'h22, 'h11, 'h12, 0, 0, 0, 0};
    expect_writes("t2", c0, 4);
    check("t2_grant_id", grant_id, 1);

    // FIFO full for 10 cycles mid-packet (longer than TIMEOUT)
    clear_logs();
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b0);
    push(0, 8'h53, 1'b1);
    c0 = cyc + 1;
    run(2);
    full = 1'b1;
    run(10);
    full = 1'b0;
    run(6);
    e_off = '{1, 12, 13, 0, 0, 0, 0, 0};
    e_dat = '{'h51, 'h52, 'h53, 0, 0, 0, 0, 0};
    expect_writes("t3", c0, 3);
    check("t3_timeouts", et_cyc.size(), 0);

    // src3 six bytes without last: length cut, re-grant, then idle timeout
    clear_logs();
    for (int k = 0; k < 6; k++) push(3, 8'h61 + 8'(k), 1'b0);
    c0 = cyc + 1;
    run(20);
    e_off = '{1, 2, 3, 4, 6, 7, 0, 0};
    e_dat = '{'h61, 'h62, 'h63, 'h64, 'h65, 'h66, 0, 0};
    expect_writes("t4", c0, 6);
    check("t4_len_pulses", el_cyc.size(), 1);
    if (el_cyc.size() > 0) check("t4_len_cycle", el_cyc[0], c0 + 5);
    check("t4_to_pulses", et_cyc.size(), 1);
    if (et_cyc.size() > 0) check("t4_to_cycle", et_cyc[0], c0 + 16);
    check("t4_grant_id", grant_id, 3);

    // src0 stalls after one byte, src1 waiting
    clear_logs();
    push(0, 8'h71, 1'b0);
    push(1, 8'h81, 1'b1);
    c0 = cyc + 1;
    run(16);
    e_off = '{1, 11, 0, 0, 0, 0, 0, 0};
    e_dat = '{'h71, 'h81, 0, 0, 0, 0, 0, 0};
    expect_writes("t5", c0, 2);
    check("t5_to_pulses", et_cyc.size(), 1);
    if (et_cyc.size() > 0) check("t5_to_cycle", et_cyc[0], c0 + 10);
    check("t5_len_pulses", el_cyc.size(), 0);
    check("t5_grant_id", grant_id, 1);

    // reset in the middle of a src2 packet
    clear_logs();
    push(2, 8'h91, 1'b0);
    push(2, 8'h92, 1'b0);
    push(2, 8'h93, 1'b1);
    c0 = cyc + 1;
    run(2);
    rst = 1'b1;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    run(1);
    rst = 1'b0;
    check("t6_rst_grant_id", grant_id, 3);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_fifo_req", bus.uart_tx_fifo_req, 0);
    check("t6_rst_src_ready", bus.src_ready, 0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hB1, 1'b1);
    c1 = cyc + 1;
    run(8);
    e_off = '{1, 4, 6, 0, 0, 0, 0, 0};
    e_dat = '{'h91, 'hA1, 'hB1, 0, 0, 0, 0, 0};
    expect_writes("t6", c0, 3);
    check("t6_restart_cycle", c1, c0 + 3);
    check("t6_err_pulses", el_cyc.size() + et_cyc.size(), 0);
    check("t6_grant_id", grant_id, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
